// File: rtl/link_playback.sv
// link_playback: replays a software-loaded BRAM buffer onto the 40 MHz link.
// Arms on a synchronised rising edge of start, waits for a BX match, a
// delayed L1A or nothing, then streams play_length words (optionally looped).
// Idle cycles carry idle_word with data_valid low.
module link_playback #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk40,
    input  logic              rst,
    input  logic [1:0]        playback_mode_in,
    input  logic              L1A_in,
    input  logic [11:0]       L1A_offset_or_bx,
    input  logic              orbitSync,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] play_length,
    input  logic [DATA_W-1:0] idle_word,
    output logic              waiting_for_trig,
    output logic              playing,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LATCH   = 3'd1;
    localparam logic [2:0] S_TRIGGER = 3'd2;
    localparam logic [2:0] S_DELAY   = 3'd3;
    localparam logic [2:0] S_START   = 3'd4;
    localparam logic [2:0] S_PLAY    = 3'd5;

    localparam logic [1:0] M_ABORT = 2'd0;
    localparam logic [1:0] M_BX    = 2'd1;
    localparam logic [1:0] M_L1A   = 2'd2;
    localparam logic [1:0] M_IMM   = 2'd3;

    logic [2:0]        r_state;
    logic [11:0]       r_orbit_cnt;
    logic [2:0]        r_start_sr;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_len;
    logic              r_loop;
    logic [11:0]       r_dly_cnt;
    logic              r_rd_valid;

    logic              w_arm;
    logic [ADDR_W-1:0] w_last_addr;

    // sr[0], sr[1] synchronise the register-driven level; sr[2] is the
    // previous synced value, so the arm pulse is a single-cycle rising edge.
    assign w_arm = r_start_sr[1] & ~r_start_sr[2];

    // A held length of zero means the whole buffer.
    assign w_last_addr = (r_len == '0) ? '1 : (r_len - 1'b1);

    // Waiting covers both the trigger wait and the L1A delay countdown.
    assign waiting_for_trig = (r_state == S_TRIGGER) || (r_state == S_DELAY);
    assign playing          = ram_en;

    // Free-running orbit position, realigned by orbitSync.
    always_ff @(posedge clk40) begin
        if (rst)
            r_orbit_cnt <= '0;
        else if (orbitSync)
            r_orbit_cnt <= '0;
        else
            r_orbit_cnt <= r_orbit_cnt + 1'b1;
    end

    // Start synchroniser / edge history.
    always_ff @(posedge clk40) begin
        if (rst)
            r_start_sr <= '0;
        else
            r_start_sr <= {r_start_sr[1:0], start};
    end

    // Playback sequencer: arm, latch config, wait for trigger, stream addresses.
    always_ff @(posedge clk40) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= M_ABORT;
            r_len     <= '0;
            r_loop    <= 1'b0;
            r_dly_cnt <= '0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
        end else if (stop && (r_state != S_IDLE)) begin
            r_state  <= S_IDLE;
            ram_en   <= 1'b0;
            ram_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ram_en   <= 1'b0;
                    ram_addr <= '0;
                    if (w_arm)
                        r_state <= S_LATCH;
                end
                S_LATCH: begin
                    // Configuration is frozen from here until back in IDLE.
                    r_mode  <= playback_mode_in;
                    r_len   <= play_length;
                    r_loop  <= loop;
                    r_state <= S_TRIGGER;
                end
                S_TRIGGER: begin
                    case (r_mode)
                        M_ABORT: r_state <= S_IDLE;
                        M_BX: begin
                            if (r_orbit_cnt == L1A_offset_or_bx)
                                r_state <= S_START;
                        end
                        M_L1A: begin
                            if (L1A_in) begin
                                r_dly_cnt <= '0;
                                r_state   <= S_DELAY;
                            end
                        end
                        M_IMM:   r_state <= S_START;
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_DELAY: begin
                    // Counts 0..offset, i.e. offset+1 cycles spent here.
                    r_dly_cnt <= r_dly_cnt + 1'b1;
                    if (r_dly_cnt == L1A_offset_or_bx)
                        r_state <= S_START;
                end
                S_START: begin
                    ram_en   <= 1'b1;
                    ram_addr <= '0;
                    r_state  <= S_PLAY;
                end
                S_PLAY: begin
                    if (ram_addr == w_last_addr) begin
                        ram_addr <= '0;
                        if (!r_loop) begin
                            ram_en  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                default: begin
                    ram_en   <= 1'b0;
                    ram_addr <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Output stage: BRAM data lands one cycle after the address, then is
    // registered onto the link; stop discards whatever is still in flight.
    always_ff @(posedge clk40) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            r_rd_valid <= ram_en & ~stop;
            if (r_rd_valid) begin
                data_out   <= ram_dout;
                data_valid <= 1'b1;
            end else begin
                data_out   <= idle_word;
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_link_playback.sv
// Directed bench for link_playback with a behavioural BRAM on port A.
`timescale 1ns/1ps
module tb_link_playback;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam logic [DW-1:0] IDLE_W = 32'hDEADBEEF;

    logic          clk40 = 1'b0;
    logic          rst;
    logic [1:0]    playback_mode_in;
    logic          L1A_in;
    logic [11:0]   L1A_offset_or_bx;
    logic          orbitSync;
    logic          start;
    logic          stop;
    logic          loop;
    logic [AW-1:0] play_length;
    logic [DW-1:0] idle_word;
    logic          waiting_for_trig;
    logic          playing;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] data_out;
    logic          data_valid;

    int total = 0;
    int bad   = 0;

    link_playback #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk40(clk40), .rst(rst), .playback_mode_in(playback_mode_in),
        .L1A_in(L1A_in), .L1A_offset_or_bx(L1A_offset_or_bx),
        .orbitSync(orbitSync), .start(start), .stop(stop), .loop(loop),
        .play_length(play_length), .idle_word(idle_word),
        .waiting_for_trig(waiting_for_trig), .playing(playing),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .data_out(data_out), .data_valid(data_valid)
    );

    always #12.5 clk40 = ~clk40;

    // Buffer content: word k = A000_0000 + k.
    function automatic logic [DW-1:0] pat(input int k);
        return 32'hA0000000 + 32'(k);
    endfunction

    // Synchronous-read BRAM port A.
    always @(posedge clk40) begin
        if (ram_en) ram_dout <= pat(int'(ram_addr));
    end

    task automatic step();
        @(posedge clk40);
        #1;
    endtask

    task automatic quiesce();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        playback_mode_in = 2'd0; L1A_in = 1'b0; L1A_offset_or_bx = 12'd0;
        orbitSync = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        play_length = '0; idle_word = IDLE_W; ram_dout = '0;
        for (int i = 0; i < 3; i++) step();
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got %b want 0", ram_en); end
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL rst_ram_addr got %0d want 0", ram_addr); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL rst_data_out got %h want 0", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid got %b want 0", data_valid); end
        total++; if (waiting_for_trig !== 1'b0) begin bad++; $display("FAIL rst_waiting got %b want 0", waiting_for_trig); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL rst_playing got %b want 0", playing); end
        rst = 1'b0;
        step();
        total++; if (data_out !== IDLE_W) begin bad++; $display("FAIL post_rst_idle got %h want %h", data_out, IDLE_W); end
        quiesce();
    endtask

    // Immediate mode, 4 words: START at cycle 5, words valid cycles 8..11.
    task automatic test_imm();
        logic          e_en, e_dv, e_wt;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dat;
        playback_mode_in = 2'd3; play_length = 13'd4; loop = 1'b0;
        step();
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            e_wt   = (c == 4);
            e_en   = (c >= 6 && c <= 9);
            e_addr = e_en ? 13'(c - 6) : 13'd0;
            e_dv   = (c >= 8 && c <= 11);
            e_dat  = e_dv ? pat(c - 8) : IDLE_W;
            total++; if (waiting_for_trig !== e_wt) begin bad++; $display("FAIL imm_wait c=%0d got %b want %b", c, waiting_for_trig, e_wt); end
            total++; if (ram_en !== e_en) begin bad++; $display("FAIL imm_en c=%0d got %b want %b", c, ram_en, e_en); end
            total++; if (ram_addr !== e_addr) begin bad++; $display("FAIL imm_addr c=%0d got %0d want %0d", c, ram_addr, e_addr); end
            total++; if (data_valid !== e_dv) begin bad++; $display("FAIL imm_dv c=%0d got %b want %b", c, data_valid, e_dv); end
            total++; if (data_out !== e_dat) begin bad++; $display("FAIL imm_data c=%0d got %h want %h", c, data_out, e_dat); end
        end
        quiesce();
    endtask

    // L1A mode, offset 10: L1A at L -> START L+12 -> first word L+15.
    task automatic test_l1a();
        playback_mode_in = 2'd2; play_length = 13'd2; loop = 1'b0;
        L1A_offset_or_bx = 12'd10;
        step();
        start = 1'b1;
        for (int c = 1; c <= 4; c++) step();
        total++; if (waiting_for_trig !== 1'b1) begin bad++; $display("FAIL l1a_armed got %b want 1", waiting_for_trig); end
        step(); step();
        L1A_in = 1'b1;
        for (int r = 1; r <= 17; r++) begin
            step();
            L1A_in = 1'b0;
            if (r == 11) begin total++; if (waiting_for_trig !== 1'b1) begin bad++; $display("FAIL l1a_wait_delay got %b want 1", waiting_for_trig); end end
            if (r == 12) begin total++; if (waiting_for_trig !== 1'b0) begin bad++; $display("FAIL l1a_wait_start got %b want 0", waiting_for_trig); end end
            if (r == 12) begin total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL l1a_en_early got %b want 0", ram_en); end end
            if (r == 13) begin total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL l1a_en got %b want 1", ram_en); end end
            if (r == 14) begin total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL l1a_dv_early got %b want 0", data_valid); end end
            if (r == 15) begin total++; if (data_out !== pat(0) || data_valid !== 1'b1) begin bad++; $display("FAIL l1a_w0 got %h/%b want %h/1", data_out, data_valid, pat(0)); end end
            if (r == 16) begin total++; if (data_out !== pat(1) || data_valid !== 1'b1) begin bad++; $display("FAIL l1a_w1 got %h/%b want %h/1", data_out, data_valid, pat(1)); end end
            if (r == 17) begin total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL l1a_end got %b want 0", data_valid); end end
        end
        quiesce();
    endtask

    // BX mode, bx 100, orbit every 3564 cycles; second arm hits the next orbit.
    task automatic test_bx();
        playback_mode_in = 2'd1; play_length = 13'd2; loop = 1'b0;
        L1A_offset_or_bx = 12'd100;
        orbitSync = 1'b1;
        step();
        start = 1'b1;
        for (int c = 1; c <= 4; c++) step();
        total++; if (waiting_for_trig !== 1'b1) begin bad++; $display("FAIL bx_armed got %b want 1", waiting_for_trig); end
        for (int r = 1; r <= 3672; r++) begin
            step();
            if (r == 1)    orbitSync = 1'b0;
            if (r == 110)  start = 1'b0;
            if (r == 120)  start = 1'b1;
            if (r == 3564) orbitSync = 1'b1;
            if (r == 3565) orbitSync = 1'b0;
            if (r == 101) begin total++; if (waiting_for_trig !== 1'b1) begin bad++; $display("FAIL bx_match_wait got %b want 1", waiting_for_trig); end end
            if (r == 102) begin total++; if (ram_en !== 1'b0 || waiting_for_trig !== 1'b0) begin bad++; $display("FAIL bx_start got en=%b wt=%b want 0/0", ram_en, waiting_for_trig); end end
            if (r == 103) begin total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL bx_en got %b want 1", ram_en); end end
            if (r == 104) begin total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL bx_dv_early got %b want 0", data_valid); end end
            if (r == 105) begin total++; if (data_out !== pat(0) || data_valid !== 1'b1) begin bad++; $display("FAIL bx_w0 got %h/%b want %h/1", data_out, data_valid, pat(0)); end end
            if (r == 130) begin total++; if (waiting_for_trig !== 1'b1) begin bad++; $display("FAIL bx_rearm got %b want 1", waiting_for_trig); end end
            if (r == 3665) begin total++; if (waiting_for_trig !== 1'b1 || ram_en !== 1'b0) begin bad++; $display("FAIL bx2_wait got wt=%b en=%b want 1/0", waiting_for_trig, ram_en); end end
            if (r == 3667) begin total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL bx2_en got %b want 1", ram_en); end end
            if (r == 3669) begin total++; if (data_out !== pat(0) || data_valid !== 1'b1) begin bad++; $display("FAIL bx2_w0 got %h/%b want %h/1", data_out, data_valid, pat(0)); end end
        end
        quiesce();
    endtask

    // Length 0 plays the full 8192-word buffer once.
    task automatic test_full_len();
        int en_cnt = 0, dv_cnt = 0, addr_err = 0, data_err = 0;
        playback_mode_in = 2'd3; play_length = 13'd0; loop = 1'b0;
        step();
        start = 1'b1;
        for (int c = 1; c <= 8205; c++) begin
            step();
            if (ram_en) begin
                en_cnt++;
                if (ram_addr !== 13'(c - 6)) addr_err++;
            end
            if (data_valid) begin
                dv_cnt++;
                if (data_out !== pat(c - 8)) data_err++;
            end
            if (c == 8197) begin total++; if (ram_addr !== 13'd8191) begin bad++; $display("FAIL full_last_addr got %0d want 8191", ram_addr); end end
        end
        total++; if (en_cnt != 8192) begin bad++; $display("FAIL full_en_cnt got %0d want 8192", en_cnt); end
        total++; if (dv_cnt != 8192) begin bad++; $display("FAIL full_dv_cnt got %0d want 8192", dv_cnt); end
        total++; if (addr_err != 0) begin bad++; $display("FAIL full_addr_seq got %0d errors want 0", addr_err); end
        total++; if (data_err != 0) begin bad++; $display("FAIL full_data_seq got %0d errors want 0", data_err); end
        total++; if (ram_en !== 1'b0 || ram_addr !== '0 || waiting_for_trig !== 1'b0) begin bad++; $display("FAIL full_idle got en=%b addr=%0d wt=%b want 0/0/0", ram_en, ram_addr, waiting_for_trig); end
        quiesce();
    endtask

    // Loop of 3 words, then stop mid-stream.
    task automatic test_loop_stop();
        playback_mode_in = 2'd3; play_length = 13'd3; loop = 1'b1;
        step();
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c >= 8 && c <= 21) begin
                total++;
                if (data_valid !== 1'b1 || data_out !== pat((c - 8) % 3)) begin
                    bad++; $display("FAIL loop_word c=%0d got %h/%b want %h/1", c, data_out, data_valid, pat((c - 8) % 3));
                end
            end
            if (c == 21) begin total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL stop_en got %b want 0", ram_en); end end
            if (c == 22) begin total++; if (data_valid !== 1'b0 || data_out !== IDLE_W) begin bad++; $display("FAIL stop_out got %h/%b want %h/0", data_out, data_valid, IDLE_W); end end
            if (c == 20) stop = 1'b1;
        end
        loop = 1'b0;
        quiesce();
    endtask

    // Start edge during PLAY is ignored; rst during PLAY resets everything.
    task automatic test_ignore_and_rst();
        playback_mode_in = 2'd3; play_length = 13'd6; loop = 1'b0;
        step();
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 8) start = 1'b0;
            if (c == 9) start = 1'b1;
            if (c == 11) begin total++; if (ram_en !== 1'b1 || ram_addr !== 13'd5) begin bad++; $display("FAIL ign_last got en=%b addr=%0d want 1/5", ram_en, ram_addr); end end
            if (c == 12) begin total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL ign_end got %b want 0", ram_en); end end
            if (c == 13) begin total++; if (waiting_for_trig !== 1'b0) begin bad++; $display("FAIL ign_rearm got %b want 0", waiting_for_trig); end end
            if (c == 13) begin total++; if (data_out !== pat(5) || data_valid !== 1'b1) begin bad++; $display("FAIL ign_w5 got %h/%b want %h/1", data_out, data_valid, pat(5)); end end
        end
        quiesce();
        step();
        start = 1'b1;
        for (int c = 1; c <= 7; c++) step();
        total++; if (ram_en !== 1'b1 || ram_addr !== 13'd1) begin bad++; $display("FAIL rstp_play got en=%b addr=%0d want 1/1", ram_en, ram_addr); end
        rst = 1'b1;
        step();
        total++; if (ram_en !== 1'b0 || playing !== 1'b0 || ram_addr !== '0) begin bad++; $display("FAIL rstp_en got en=%b pl=%b addr=%0d want 0/0/0", ram_en, playing, ram_addr); end
        total++; if (data_out !== '0 || data_valid !== 1'b0) begin bad++; $display("FAIL rstp_out got %h/%b want 0/0", data_out, data_valid); end
        total++; if (waiting_for_trig !== 1'b0) begin bad++; $display("FAIL rstp_wait got %b want 0", waiting_for_trig); end
        rst = 1'b0;
        quiesce();
    endtask

    initial begin
        test_reset();
        test_imm();
        test_l1a();
        test_bx();
        test_full_len();
        test_loop_stop();
        test_ignore_and_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
